// File: rtl/acc_button_ctrl_pkg.sv
// Shared types and default timing constants for the accumulator button front-end.
package acc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HOLD_PLUS  = 2'd1,
    HOLD_MINUS = 2'd2,
    LOCK       = 2'd3
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_DELAY    = 8;
  localparam int DEF_REPEAT_PERIOD   = 4;
  localparam int DEF_CNT_W           = 16;

endpackage

// File: rtl/acc_button_ctrl_if.sv
// Button-side and accumulator-side signals of the button controller.
interface acc_button_ctrl_if;

  logic btn_plus_raw;
  logic btn_minus_raw;
  logic btn_clear_raw;
  logic cmd_plus;
  logic cmd_minus;
  logic cmd_clear;
  logic locked;

  modport master (
    output btn_plus_raw, btn_minus_raw, btn_clear_raw,
    input  cmd_plus, cmd_minus, cmd_clear, locked
  );

  modport slave (
    input  btn_plus_raw, btn_minus_raw, btn_clear_raw,
    output cmd_plus, cmd_minus, cmd_clear, locked
  );

endinterface

// File: rtl/acc_button_ctrl_btn_debounce.sv
// Two-flop synchroniser plus run-length debouncer for one raw push-button;
// emits the clean level and a one-cycle strobe on its rising edge.
module btn_debounce
  import acc_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      // Any sample agreeing with the current level restarts the stability run.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_LAST) begin
        r_level <= r_sync2;
        r_rise  <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/acc_button_ctrl.sv
// Debounced plus/minus/clear buttons -> mutually exclusive one-cycle accumulator
// commands. Define AUTO_REPEAT_EN to enable auto-repeat while a step button is held.
module acc_button_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input logic               clk,
  input logic               reset,
  acc_button_ctrl_if.slave  bus
);

`ifdef AUTO_REPEAT_EN
  localparam bit LP_REP_EN = 1'b1;
`else
  localparam bit LP_REP_EN = 1'b0;
`endif
  // After each repeat pulse the counter restarts part-way so later pulses use the shorter period.
  localparam logic [CNT_W-1:0] LP_REP_LAST   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] LP_REP_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic w_plus_lvl,  w_plus_rise;
  logic w_minus_lvl, w_minus_rise;
  logic w_clear_lvl, w_clear_rise;
  logic w_rep_fire;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_plus (
    .clk(clk), .reset(reset), .i_raw(bus.btn_plus_raw),
    .o_level(w_plus_lvl), .o_rise(w_plus_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_minus (
    .clk(clk), .reset(reset), .i_raw(bus.btn_minus_raw),
    .o_level(w_minus_lvl), .o_rise(w_minus_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_clear (
    .clk(clk), .reset(reset), .i_raw(bus.btn_clear_raw),
    .o_level(w_clear_lvl), .o_rise(w_clear_rise)
  );

  state_t           r_state;
  logic             r_cmd_plus;
  logic             r_cmd_minus;
  logic             r_cmd_clear;
  logic             r_locked;
  logic [CNT_W-1:0] r_rep_cnt;

  assign w_rep_fire = LP_REP_EN && (r_rep_cnt == LP_REP_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cmd_plus  <= 1'b0;
      r_cmd_minus <= 1'b0;
      r_cmd_clear <= 1'b0;
      r_locked    <= 1'b0;
      r_rep_cnt   <= '0;
    end else begin
      r_cmd_plus  <= 1'b0;
      r_cmd_minus <= 1'b0;
      r_cmd_clear <= 1'b0;
      r_rep_cnt   <= '0;
      case (r_state)
        IDLE: begin
          if (w_clear_rise) begin
            r_cmd_clear <= 1'b1;
            r_state     <= LOCK;
            r_locked    <= 1'b1;
          end else if ((w_plus_rise || w_minus_rise) && w_plus_lvl && w_minus_lvl) begin
            r_state  <= LOCK;
            r_locked <= 1'b1;
          end else if (w_plus_rise) begin
            r_cmd_plus <= 1'b1;
            r_state    <= HOLD_PLUS;
          end else if (w_minus_rise) begin
            r_cmd_minus <= 1'b1;
            r_state     <= HOLD_MINUS;
          end
        end
        HOLD_PLUS: begin
          if (w_clear_rise) begin
            r_cmd_clear <= 1'b1;
            r_state     <= LOCK;
            r_locked    <= 1'b1;
          end else if (!w_plus_lvl) begin
            r_state <= IDLE;
          end else if (w_minus_lvl) begin
            r_state  <= LOCK;
            r_locked <= 1'b1;
          end else if (w_rep_fire) begin
            r_cmd_plus <= 1'b1;
            r_rep_cnt  <= LP_REP_RELOAD;
          end else begin
            r_rep_cnt <= r_rep_cnt + CNT_W'(1);
          end
        end
        HOLD_MINUS: begin
          if (w_clear_rise) begin
            r_cmd_clear <= 1'b1;
            r_state     <= LOCK;
            r_locked    <= 1'b1;
          end else if (!w_minus_lvl) begin
            r_state <= IDLE;
          end else if (w_plus_lvl) begin
            r_state  <= LOCK;
            r_locked <= 1'b1;
          end else if (w_rep_fire) begin
            r_cmd_minus <= 1'b1;
            r_rep_cnt   <= LP_REP_RELOAD;
          end else begin
            r_rep_cnt <= r_rep_cnt + CNT_W'(1);
          end
        end
        default: begin
          if (w_clear_rise) begin
            r_cmd_clear <= 1'b1;
          end else if (!w_plus_lvl && !w_minus_lvl && !w_clear_lvl) begin
            r_state  <= IDLE;
            r_locked <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.cmd_plus  = r_cmd_plus;
  assign bus.cmd_minus = r_cmd_minus;
  assign bus.cmd_clear = r_cmd_clear;
  assign bus.locked    = r_locked;

endmodule
